axis_frame_gen: RTL and testbench

AXI4-Stream frame source that drives incrementing-count data frames of programmable length onto a master stream. It is the transmitting end of the pipeline and feeds stages such as the gating skid buffer. It obeys full `m_axis_tready` backpressure and starts or stops only on frame boundaries. Bring-up benches and on-board loopback tests use it as the traffic generator.

---
 rtl/axis_frame_gen_pkg.sv | 14 +
 rtl/axis_frame_gen.sv | 124 ++++++++++++
 tb/tb_axis_frame_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_pkg
// Shared constants for the AXI4-Stream frame generator.
//   AFG_DATA_WIDTH   default payload / data counter width
//   AFG_LEN_WIDTH    default frame length / beat counter width
//   AFG_COUNT_WIDTH  width of the completed-frame counter
// -----------------------------------------------------------------------------
package axis_frame_gen_pkg;

  localparam int unsigned AFG_DATA_WIDTH  = 32;
  localparam int unsigned AFG_LEN_WIDTH   = 16;
  localparam int unsigned AFG_COUNT_WIDTH = 32;

endpackage : axis_frame_gen_pkg

// File: rtl/axis_frame_gen.sv
// -----------------------------------------------------------------------------
// axis_frame_gen
// AXI4-Stream frame source. Emits frames of frame_len beats whose payload is a
// free-running, wrapping data counter. Starts and stops only on frame
// boundaries and honours full m_axis_tready backpressure.
//
// Ports:
//   aclk           clock, rising edge
//   areset         synchronous active-high reset
//   enable         run request, sampled in IDLE and on the tlast handshake
//   frame_len      beats per frame, latched at frame start (0 behaves as 1)
//   m_axis_tdata   beat payload (running data counter)
//   m_axis_tvalid  beat valid
//   m_axis_tready  sink ready
//   m_axis_tlast   last beat of the frame
//   busy           high while running
//   frame_count    completed frames, wraps modulo 2^32
// -----------------------------------------------------------------------------
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AFG_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = AFG_LEN_WIDTH
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       enable,
  input  logic [LEN_WIDTH-1:0]       frame_len,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic [AFG_COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                     state_reg, state_next;
  logic [DATA_WIDTH-1:0]      data_cnt_reg, data_cnt_next;
  logic [LEN_WIDTH-1:0]       beat_cnt_reg, beat_cnt_next;
  logic [LEN_WIDTH-1:0]       len_q_reg, len_q_next;
  logic [AFG_COUNT_WIDTH-1:0] frame_count_reg, frame_count_next;

  logic [LEN_WIDTH-1:0] frame_len_eff;
  logic [LEN_WIDTH-1:0] last_beat_idx;
  logic                 is_last;
  logic                 handshake;

  // A zero-length request still produces one beat.
  assign frame_len_eff = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;

  // tlast is decoded purely from registered state so it never follows tready.
  assign last_beat_idx = len_q_reg - LEN_WIDTH'(1);
  assign is_last       = (state_reg == ST_RUN) && (beat_cnt_reg == last_beat_idx);
  assign handshake     = (state_reg == ST_RUN) && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg       <= ST_IDLE;
      data_cnt_reg    <= '0;
      beat_cnt_reg    <= '0;
      len_q_reg       <= '0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      data_cnt_reg    <= data_cnt_next;
      beat_cnt_reg    <= beat_cnt_next;
      len_q_reg       <= len_q_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    data_cnt_next    = data_cnt_reg;
    beat_cnt_next    = beat_cnt_reg;
    len_q_next       = len_q_reg;
    frame_count_next = frame_count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next    = ST_RUN;
          len_q_next    = frame_len_eff;
          beat_cnt_next = '0;
        end
      end

      ST_RUN: begin
        if (handshake) begin
          // The payload counter runs continuously across frames and idle gaps.
          data_cnt_next = data_cnt_reg + DATA_WIDTH'(1);
          if (is_last) begin
            frame_count_next = frame_count_reg + AFG_COUNT_WIDTH'(1);
            beat_cnt_next    = '0;
            if (enable) begin
              // Back-to-back frame: relatch length, no idle bubble.
              len_q_next = frame_len_eff;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign m_axis_tvalid = (state_reg == ST_RUN);
  assign m_axis_tdata  = data_cnt_reg;
  assign m_axis_tlast  = is_last;
  assign busy          = (state_reg == ST_RUN);
  assign frame_count   = frame_count_reg;

endmodule : axis_frame_gen

// File: tb/tb_axis_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_gen
// Directed bench for axis_frame_gen with a 4-bit data counter so that the
// payload wrap can be reached in a short run.
// -----------------------------------------------------------------------------
module tb_axis_frame_gen;

  localparam int unsigned DW = 4;
  localparam int unsigned LW = 16;

  logic          aclk;
  logic          areset;
  logic          enable;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   frame_count;

  int total_checks;
  int passed_checks;

  logic [31:0] cap_d[$];
  logic        cap_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  logic          stall_pending;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  axis_frame_gen #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .frame_len     (frame_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      passed_checks++;
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Record handshakes and verify that a stalled beat holds steady.
  always @(negedge aclk) begin
    if (!areset) begin
      if (stall_pending) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", 32'(m_axis_tdata), 32'(stall_data));
        check("stall_last", 32'(m_axis_tlast), 32'(stall_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_d.push_back(32'(m_axis_tdata));
        cap_l.push_back(m_axis_tlast);
      end
      stall_pending = m_axis_tvalid && !m_axis_tready;
      stall_data    = m_axis_tdata;
      stall_last    = m_axis_tlast;
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    step();
    step();
    areset = 1'b0;
    cap_d.delete();
    cap_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check($sformatf("%s_beats", tag), 32'(cap_d.size()), 32'(exp_d.size()));
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(cap_l[i]), 32'(exp_l[i]));
    end
    cap_d.delete();
    cap_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  initial begin
    logic [3:0] pat;
    total_checks  = 0;
    passed_checks = 0;
    stall_pending = 1'b0;
    stall_data    = '0;
    stall_last    = 1'b0;
    frame_len     = '0;

    // Reset values.
    do_reset();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", frame_count, 32'd0);

    // Single 4-beat frame, tready held high.
    frame_len = 16'd4;
    enable    = 1'b1;
    step();
    check("t1_start_valid", 32'(m_axis_tvalid), 32'd1);
    check("t1_start_data", 32'(m_axis_tdata), 32'd0);
    check("t1_start_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 1);
    compare_beats("t1");
    check("t1_frame_count", frame_count, 32'd1);
    check("t1_end_valid", 32'(m_axis_tvalid), 32'd0);

    // Same frame under tready 1,0,0,1 backpressure.
    do_reset();
    frame_len = 16'd4;
    enable    = 1'b1;
    pat       = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      m_axis_tready = pat[i % 4];
      if (i == 1) enable = 1'b0;
      step();
    end
    m_axis_tready = 1'b1;
    step();
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 1);
    compare_beats("t2");
    check("t2_frame_count", frame_count, 32'd1);

    // Back-to-back 3-beat frames, enable dropped during beat 4.
    do_reset();
    frame_len = 16'd3;
    enable    = 1'b1;
    step();
    step();
    step();
    step();
    check("t3_nobubble_valid", 32'(m_axis_tvalid), 32'd1);
    check("t3_nobubble_data", 32'(m_axis_tdata), 32'd3);
    step();
    check("t3_beat4_data", 32'(m_axis_tdata), 32'd4);
    enable = 1'b0;
    step();
    step();
    check("t3_stop_valid", 32'(m_axis_tvalid), 32'd0);
    check("t3_stop_busy", 32'(busy), 32'd0);
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(2, 1);
    expect_beat(3, 0); expect_beat(4, 0); expect_beat(5, 1);
    compare_beats("t3");
    check("t3_frame_count", frame_count, 32'd2);

    // frame_len of 0 behaves as a single-beat frame.
    do_reset();
    frame_len = 16'd0;
    enable    = 1'b1;
    step();
    check("t4_first_last", 32'(m_axis_tlast), 32'd1);
    enable = 1'b0;
    step();
    step();
    expect_beat(0, 1);
    compare_beats("t4");
    check("t4_frame_count", frame_count, 32'd1);

    // Reset in the middle of a 5-beat frame.
    do_reset();
    frame_len = 16'd5;
    enable    = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    areset = 1'b1;
    step();
    check("t5_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("t5_rst_last", 32'(m_axis_tlast), 32'd0);
    check("t5_rst_data", 32'(m_axis_tdata), 32'd0);
    check("t5_rst_frame_count", frame_count, 32'd0);
    areset = 1'b0;
    enable = 1'b1;
    step();
    check("t5_restart_data", 32'(m_axis_tdata), 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
    expect_beat(0, 0); expect_beat(1, 0);
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    compare_beats("t5");
    check("t5_frame_count", frame_count, 32'd1);

    // 13-beat frame brings the counter to 13, then a 20-beat frame wraps it.
    // The frame_len change during the first frame only takes effect at relatch.
    do_reset();
    frame_len = 16'd13;
    enable    = 1'b1;
    step();
    frame_len = 16'd20;
    for (int i = 0; i < 14; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 13; i++) expect_beat(32'(i), (i == 12));
    for (int i = 0; i < 20; i++) expect_beat(32'((13 + i) % 16), (i == 19));
    compare_beats("t6");
    check("t6_frame_count", frame_count, 32'd2);
    check("t6_end_valid", 32'(m_axis_tvalid), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule : tb_axis_frame_gen
